// File: rtl/dispatch_ctrl.sv
// Two-entry dispatch buffer: allocates ROB tags, routes to RS/LSB, snoops result broadcasts.
// Optional stall counters are enabled by defining DISPATCH_STATS_EN.
module dispatch_ctrl #(
  parameter int ROB_TAG_W = 4,
  parameter int OP_W      = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 rollback,
  input  logic                 dc_valid,
  output logic                 dc_ready,
  input  logic [6:0]           dc_opType,
  input  logic [OP_W-1:0]      dc_op,
  input  logic [31:0]          dc_rs1_val,
  input  logic [31:0]          dc_rs2_val,
  input  logic [ROB_TAG_W-1:0] dc_rs1_depend,
  input  logic [ROB_TAG_W-1:0] dc_rs2_depend,
  input  logic [4:0]           dc_rd,
  input  logic [31:0]          dc_imm,
  input  logic [31:0]          dc_PC,
  input  logic                 dc_pred_br,
  input  logic                 rob_full,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  input  logic                 alu_result_ready,
  input  logic [ROB_TAG_W-1:0] alu_result_rob_index,
  input  logic [31:0]          alu_result_val,
  input  logic                 lsb_result_ready,
  input  logic [ROB_TAG_W-1:0] lsb_result_rob_index,
  input  logic [31:0]          lsb_result_val,
  output logic                 issue_rob_valid,
  output logic                 issue_rs_valid,
  output logic                 issue_lsb_valid,
  output logic [ROB_TAG_W-1:0] issue_tag,
  output logic [6:0]           issue_opType,
  output logic [OP_W-1:0]      issue_op,
  output logic [31:0]          issue_rs1_val,
  output logic [ROB_TAG_W-1:0] issue_rs1_depend,
  output logic [31:0]          issue_rs2_val,
  output logic [ROB_TAG_W-1:0] issue_rs2_depend,
  output logic [4:0]           issue_rd,
  output logic [31:0]          issue_imm,
  output logic [31:0]          issue_PC,
  output logic                 issue_pred_br
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]          stat_stall_rob,
  output logic [31:0]          stat_stall_rs,
  output logic [31:0]          stat_stall_lsb
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [ROB_TAG_W-1:0] TAG_ONE = {{(ROB_TAG_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [6:0]           optype;
    logic [OP_W-1:0]      op;
    logic [31:0]          rs1_val;
    logic [ROB_TAG_W-1:0] rs1_dep;
    logic [31:0]          rs2_val;
    logic [ROB_TAG_W-1:0] rs2_dep;
    logic [4:0]           rd;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic                 pred;
  } entry_t;

  logic [1:0]           state_q, state_d;
  logic [ROB_TAG_W-1:0] tag_q, tag_d;
  entry_t               ent_q [2];
  entry_t               ent_d [2];
  entry_t               dc_ent, head_fwd;
  logic                 head_valid, head_lsb, target_full, issue_fire, push;

  // ALU broadcast has priority when both buses carry the same tag.
  function automatic logic [31:0] fwd_val(input logic [31:0] v, input logic [ROB_TAG_W-1:0] d);
    if (d != '0 && alu_result_ready && alu_result_rob_index == d)      return alu_result_val;
    else if (d != '0 && lsb_result_ready && lsb_result_rob_index == d) return lsb_result_val;
    else                                                               return v;
  endfunction

  function automatic logic [ROB_TAG_W-1:0] fwd_dep(input logic [ROB_TAG_W-1:0] d);
    if ((alu_result_ready && alu_result_rob_index == d) ||
        (lsb_result_ready && lsb_result_rob_index == d)) return '0;
    else                                                 return d;
  endfunction

  function automatic entry_t wake(input entry_t e);
    entry_t r;
    r         = e;
    r.rs1_val = fwd_val(e.rs1_val, e.rs1_dep);
    r.rs1_dep = fwd_dep(e.rs1_dep);
    r.rs2_val = fwd_val(e.rs2_val, e.rs2_dep);
    r.rs2_dep = fwd_dep(e.rs2_dep);
    return r;
  endfunction

  always_comb begin
    dc_ent = '{optype: dc_opType, op: dc_op, rs1_val: dc_rs1_val, rs1_dep: dc_rs1_depend,
               rs2_val: dc_rs2_val, rs2_dep: dc_rs2_depend, rd: dc_rd, imm: dc_imm,
               pc: dc_PC, pred: dc_pred_br};
    head_fwd = wake(ent_q[0]);
  end

  assign head_valid  = (state_q == S_ONE) || (state_q == S_TWO);
  assign head_lsb    = (ent_q[0].optype == 7'b0000011) || (ent_q[0].optype == 7'b0100011);
  assign target_full = head_lsb ? lsb_full : rs_full;
  assign issue_fire  = head_valid && rdy_in && !rollback && !rob_full && !target_full;
  assign dc_ready    = rst_in && rdy_in && !rollback && ((state_q == S_EMPTY) || (state_q == S_ONE));
  assign push        = dc_valid && dc_ready;

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    if (rdy_in) begin
      ent_d[0] = wake(ent_q[0]);
      ent_d[1] = wake(ent_q[1]);
      if (rollback) begin
        state_d = S_FLUSH;
        tag_d   = TAG_ONE;
      end else begin
        if (issue_fire) tag_d = (tag_q == '1) ? TAG_ONE : tag_q + TAG_ONE;
        case (state_q)
          S_FLUSH: state_d = S_EMPTY;
          S_EMPTY: if (push) begin
            ent_d[0] = wake(dc_ent);
            state_d  = S_ONE;
          end
          S_ONE: begin
            if (push && issue_fire) ent_d[0] = wake(dc_ent);
            else if (push) begin
              ent_d[1] = wake(dc_ent);
              state_d  = S_TWO;
            end else if (issue_fire) state_d = S_EMPTY;
          end
          S_TWO: if (issue_fire) begin
            ent_d[0] = wake(ent_q[1]);
            state_d  = S_ONE;
          end
          default: state_d = S_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_EMPTY;
      tag_q    <= TAG_ONE;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

  always_comb begin
    issue_rob_valid  = issue_fire;
    issue_rs_valid   = issue_fire && !head_lsb;
    issue_lsb_valid  = issue_fire && head_lsb;
    issue_tag        = '0;
    issue_opType     = '0;
    issue_op         = '0;
    issue_rs1_val    = '0;
    issue_rs1_depend = '0;
    issue_rs2_val    = '0;
    issue_rs2_depend = '0;
    issue_rd         = '0;
    issue_imm        = '0;
    issue_PC         = '0;
    issue_pred_br    = 1'b0;
    if (issue_fire) begin
      issue_tag        = tag_q;
      issue_opType     = head_fwd.optype;
      issue_op         = head_fwd.op;
      issue_rs1_val    = head_fwd.rs1_val;
      issue_rs1_depend = head_fwd.rs1_dep;
      issue_rs2_val    = head_fwd.rs2_val;
      issue_rs2_depend = head_fwd.rs2_dep;
      issue_rd         = head_fwd.rd;
      issue_imm        = head_fwd.imm;
      issue_PC         = head_fwd.pc;
      issue_pred_br    = head_fwd.pred;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic stall_rob, stall_rs, stall_lsb;
  assign stall_rob = head_valid && rdy_in && rob_full;
  assign stall_rs  = head_valid && rdy_in && !rob_full && !head_lsb && rs_full;
  assign stall_lsb = head_valid && rdy_in && !rob_full && head_lsb && lsb_full;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_stall_rob <= '0;
      stat_stall_rs  <= '0;
      stat_stall_lsb <= '0;
    end else begin
      if (stall_rob && stat_stall_rob != '1) stat_stall_rob <= stat_stall_rob + 32'd1;
      if (stall_rs  && stat_stall_rs  != '1) stat_stall_rs  <= stat_stall_rs  + 32'd1;
      if (stall_lsb && stat_stall_lsb != '1) stat_stall_lsb <= stat_stall_lsb + 32'd1;
    end
  end
`endif

endmodule
